// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline types: the IF->ID entry record and the canonical NOP encoding.
package rv32_pipe_pkg;

  localparam int unsigned RV32_XLEN = 32;
  localparam int unsigned RV32_ILEN = 32;

  // ADDI x0, x0, 0
  localparam logic [RV32_ILEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [RV32_XLEN-1:0] pc;
    logic [RV32_ILEN-1:0] code;
  } if_id_entry_t;

endpackage

// File: rtl/rv32_if_id_fifo.sv
// IF->ID instruction buffer: DEPTH-entry FIFO of {pc, code} with flush, presenting a NOP when empty.
module rv32_if_id_fifo
  import rv32_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [ILEN-1:0]          push_code,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [ILEN-1:0]          code_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_depth_check
    $error("rv32_if_id_fifo: DEPTH must be a power of two and at least 2");
  end
  if ((XLEN != RV32_XLEN) || (ILEN != RV32_ILEN)) begin : gen_width_check
    $error("rv32_if_id_fifo: XLEN/ILEN must match rv32_pipe_pkg entry widths");
  end

  if_id_entry_t     mem [DEPTH];
  if_id_entry_t     head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             full, empty;
  logic             push_fire, pop_fire;

  // full/empty come from the count so equal pointers are never ambiguous
  assign full      = (cnt_q == FullCount);
  assign empty     = (cnt_q == '0);
  assign push_fire = push_valid & ~full;
  assign pop_fire  = pop_ready & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push_fire && !pop_fire) begin
        cnt_q <= cnt_q + CntOne;
      end else if (pop_fire && !push_fire) begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

  // Storage carries no reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      mem[wr_ptr_q] <= '{pc: push_pc, code: push_code};
    end
  end

  always_comb begin
    head       = mem[rd_ptr_q];
    push_ready = ~full;
    pop_valid  = ~empty;
    code_out   = empty ? RV32_NOP : head.code;
    pc_out     = empty ? '0 : head.pc;
    count      = cnt_q;
  end

endmodule

// File: tb/tb_rv32_if_id_fifo.sv
// Directed bench for rv32_if_id_fifo: vector table plus hand sequences for wrap and async reset.
module tb_rv32_if_id_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_code;
  logic [31:0] push_pc;
  logic        pop_ready;
  logic        pop_valid;
  logic [31:0] code_out;
  logic [31:0] pc_out;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  rv32_if_id_fifo #(.XLEN(32), .ILEN(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_code  (push_code),
    .push_pc    (push_pc),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .code_out   (code_out),
    .pc_out     (pc_out),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        push_valid;
    logic [31:0] pc;
    logic [31:0] code;
    logic        pop_ready;
    logic        exp_pop_valid;
    logic        exp_push_ready;
    logic [2:0]  exp_count;
    logic [31:0] exp_pc;
    logic [31:0] exp_code;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic pv, input logic pr, input logic [2:0] c,
                           input logic [31:0] pc, input logic [31:0] code);
    check({tag, " pop_valid"}, {31'b0, pop_valid}, {31'b0, pv});
    check({tag, " push_ready"}, {31'b0, push_ready}, {31'b0, pr});
    check({tag, " count"}, {29'b0, count}, {29'b0, c});
    check({tag, " pc_out"}, pc_out, pc);
    check({tag, " code_out"}, code_out, code);
  endtask

  function automatic vec_t mk(logic fl, logic pv, logic [31:0] pc, logic [31:0] code, logic pr,
                              logic epv, logic epr, logic [2:0] ec, logic [31:0] epc,
                              logic [31:0] ecode);
    vec_t v;
    v.flush = fl; v.push_valid = pv; v.pc = pc; v.code = code; v.pop_ready = pr;
    v.exp_pop_valid = epv; v.exp_push_ready = epr; v.exp_count = ec;
    v.exp_pc = epc; v.exp_code = ecode;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic pv, input logic [31:0] pc,
                       input logic [31:0] code, input logic pr);
    flush = fl; push_valid = pv; push_pc = pc; push_code = code; pop_ready = pr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flush push pc code pop | pv pr cnt pc code
    vecs[0]  = mk(0, 1, 32'h100, 32'h0050_0093, 0, 1, 1, 1, 32'h100, 32'h0050_0093);
    vecs[1]  = mk(0, 0, 32'h0,   32'h0,          1, 0, 1, 0, 32'h0,   32'h0000_0013);
    vecs[2]  = mk(0, 1, 32'h0,   32'h0010_0093, 0, 1, 1, 1, 32'h0,   32'h0010_0093);
    vecs[3]  = mk(0, 1, 32'h4,   32'h0020_0093, 0, 1, 1, 2, 32'h0,   32'h0010_0093);
    vecs[4]  = mk(0, 1, 32'h8,   32'h0030_0093, 0, 1, 1, 3, 32'h0,   32'h0010_0093);
    vecs[5]  = mk(0, 1, 32'hC,   32'h0040_0093, 0, 1, 0, 4, 32'h0,   32'h0010_0093);
    vecs[6]  = mk(0, 1, 32'h10,  32'h0050_0093, 0, 1, 0, 4, 32'h0,   32'h0010_0093);
    vecs[7]  = mk(0, 0, 32'h0,   32'h0,          1, 1, 1, 3, 32'h4,   32'h0020_0093);
    vecs[8]  = mk(0, 0, 32'h0,   32'h0,          1, 1, 1, 2, 32'h8,   32'h0030_0093);
    vecs[9]  = mk(0, 0, 32'h0,   32'h0,          1, 1, 1, 1, 32'hC,   32'h0040_0093);
    vecs[10] = mk(0, 0, 32'h0,   32'h0,          1, 0, 1, 0, 32'h0,   32'h0000_0013);
    vecs[11] = mk(0, 1, 32'h200, 32'h0060_0093, 0, 1, 1, 1, 32'h200, 32'h0060_0093);
    vecs[12] = mk(0, 1, 32'h204, 32'h0070_0093, 0, 1, 1, 2, 32'h200, 32'h0060_0093);
    vecs[13] = mk(0, 1, 32'h208, 32'h0080_0093, 0, 1, 1, 3, 32'h200, 32'h0060_0093);
    // flush beats the simultaneous push and pop
    vecs[14] = mk(1, 1, 32'h20C, 32'h0090_0093, 1, 0, 1, 0, 32'h0,   32'h0000_0013);
    vecs[15] = mk(0, 0, 32'h0,   32'h0,          1, 0, 1, 0, 32'h0,   32'h0000_0013);
    vecs[16] = mk(0, 1, 32'h300, 32'h00A0_0093, 1, 1, 1, 1, 32'h300, 32'h00A0_0093);
    vecs[17] = mk(0, 0, 32'h0,   32'h0,          1, 0, 1, 0, 32'h0,   32'h0000_0013);

    // Reset and idle
    rst = 1'b1;
    drive(0, 0, 32'h0, 32'h0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all("reset_idle", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0013);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].flush, vecs[i].push_valid, vecs[i].pc, vecs[i].code, vecs[i].pop_ready);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pop_valid, vecs[i].exp_push_ready,
                vecs[i].exp_count, vecs[i].exp_pc, vecs[i].exp_code);
    end

    // Streaming push+pop: occupancy stays at 1 while pointers wrap twice
    drive(0, 1, 32'h0, {12'd0, 20'h00093}, 0);
    tick();
    check_all("stream0", 1'b1, 1'b1, 3'd1, 32'h0, {12'd0, 20'h00093});
    for (int i = 1; i < 10; i++) begin
      drive(0, 1, 32'(4 * i), {12'(i), 20'h00093}, 1);
      tick();
      check_all($sformatf("stream%0d", i), 1'b1, 1'b1, 3'd1, 32'(4 * i), {12'(i), 20'h00093});
    end
    drive(0, 0, 32'h0, 32'h0, 1);
    tick();
    check_all("stream_drain", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0013);

    // Async reset mid-cycle with two entries held
    drive(0, 1, 32'h500, 32'h00B0_0093, 0);
    tick();
    drive(0, 1, 32'h504, 32'h00C0_0093, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0);
    check_all("pre_rst", 1'b1, 1'b1, 3'd2, 32'h500, 32'h00B0_0093);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0013);
    tick();
    rst = 1'b0;
    drive(0, 1, 32'h400, 32'h00D0_0093, 0);
    #1;
    check_all("post_rst_pre_edge", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_0013);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0);
    check_all("post_rst_push", 1'b1, 1'b1, 3'd1, 32'h400, 32'h00D0_0093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
